// File: rtl/ripple_adder_4_pkg.sv
// Shared constants for the 4-bit registered ripple-carry adder.
package ripple_adder_4_pkg;

  localparam int RA4_WIDTH = 4;
  localparam int RA4_SUM_W = RA4_WIDTH + 1;

  localparam logic [RA4_SUM_W-1:0] RA4_S_RST = '0;

endpackage

// File: rtl/ripple_adder_4_full_adder.sv
// 1-bit combinational full adder, one stage of the ripple chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/ripple_adder_4.sv
// 4-bit registered ripple-carry adder: s = a + b + ci, carry-out in s[4].
// Optional registered signed-overflow output under RIPPLE_ADDER_4_OVF_EN.
module ripple_adder_4
  import ripple_adder_4_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [RA4_WIDTH-1:0] a,
  input  logic [RA4_WIDTH-1:0] b,
  input  logic                 ci,
  output logic [RA4_SUM_W-1:0] s
`ifdef RIPPLE_ADDER_4_OVF_EN
  ,
  output logic                 ovf
`endif
);

  // carry[i] feeds stage i; carry[RA4_WIDTH] is the carry-out.
  logic [RA4_WIDTH:0]   carry;
  logic [RA4_WIDTH-1:0] sum_bits;
  logic [RA4_SUM_W-1:0] s_next;

  assign carry[0] = ci;

  for (genvar i = 0; i < RA4_WIDTH; i++) begin : g_stage
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .sum  (sum_bits[i]),
      .cout (carry[i+1])
    );
  end

  assign s_next = {carry[RA4_WIDTH], sum_bits};

  always_ff @(posedge clk) begin
    if (rst) begin
      s <= RA4_S_RST;
    end else begin
      s <= s_next;
    end
  end

`ifdef RIPPLE_ADDER_4_OVF_EN
  logic ovf_next;

  // Signed overflow: carry into the sign bit differs from carry out of it.
  assign ovf_next = carry[RA4_WIDTH] ^ carry[RA4_WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else begin
      ovf <= ovf_next;
    end
  end
`endif

endmodule

// File: tb/tb_ripple_adder_4.sv
// Directed and exhaustive bench for ripple_adder_4; follows RIPPLE_ADDER_4_OVF_EN.
module tb_ripple_adder_4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] a   = '0;
  logic [3:0] b   = '0;
  logic       ci  = 1'b0;
  logic [4:0] s;
`ifdef RIPPLE_ADDER_4_OVF_EN
  logic       ovf;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  // {ovf, s} expected per cycle
  logic [5:0] exp_q[$];

  always #5 clk = ~clk;

  ripple_adder_4 dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .ci  (ci),
    .s   (s)
`ifdef RIPPLE_ADDER_4_OVF_EN
    ,
    .ovf (ovf)
`endif
  );

  // Apply one vector at the falling edge, return 1 time unit after the next rising edge.
  task automatic drive(input logic r, input logic [3:0] av, input logic [3:0] bv, input logic cv);
    @(negedge clk);
    rst = r;
    a   = av;
    b   = bv;
    ci  = cv;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 4'b1111, 4'b1111, 1'b1);
      total_cnt++;
      if (s !== 5'b00000) $display("FAIL reset_s cycle %0d: got %b expected 00000", i, s);
      else pass_cnt++;
`ifdef RIPPLE_ADDER_4_OVF_EN
      total_cnt++;
      if (ovf !== 1'b0) $display("FAIL reset_ovf cycle %0d: got %b expected 0", i, ovf);
      else pass_cnt++;
`endif
    end
    drive(1'b0, 4'b1111, 4'b1111, 1'b1);
    total_cnt++;
    if (s !== 5'b11111) $display("FAIL reset_release: got %b expected 11111", s);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    logic [3:0] av, bv;
    logic       cv;
    logic [4:0] ev;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0:       begin av = 4'b0001; bv = 4'b1101; cv = 1'b1; ev = 5'b01111; end
        1:       begin av = 4'b0101; bv = 4'b1001; cv = 1'b1; ev = 5'b01111; end
        2:       begin av = 4'b1101; bv = 4'b1111; cv = 1'b0; ev = 5'b11100; end
        3:       begin av = 4'b0111; bv = 4'b1101; cv = 1'b1; ev = 5'b10101; end
        4:       begin av = 4'b1101; bv = 4'b1101; cv = 1'b0; ev = 5'b11010; end
        default: begin av = 4'b1001; bv = 4'b1101; cv = 1'b1; ev = 5'b10111; end
      endcase
      drive(1'b0, av, bv, cv);
      total_cnt++;
      if (s !== ev) $display("FAIL basic_%0d a=%b b=%b ci=%b: got %b expected %b", i, av, bv, cv, s, ev);
      else pass_cnt++;
    end
  endtask

  task automatic test_hold();
    drive(1'b0, 4'b0011, 4'b0100, 1'b1);
    // Wiggle inputs between edges; the register must not follow them.
    a  = 4'b1111;
    b  = 4'b1111;
    ci = 1'b1;
    #2;
    a  = 4'b1010;
    b  = 4'b0110;
    ci = 1'b0;
    #1;
    total_cnt++;
    if (s !== 5'b01000) $display("FAIL hold: got %b expected 01000", s);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [5:0] ev;
    logic [3:0] av, bv;
    logic       cv;
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        ev = exp_q.pop_front();
        total_cnt++;
        if (s !== ev[4:0]) $display("FAIL back_to_back_%0d: got %b expected %b", i - 1, s, ev[4:0]);
        else pass_cnt++;
      end
      if (i < 8) begin
        av = 4'($urandom_range(0, 15));
        bv = 4'($urandom_range(0, 15));
        cv = 1'($urandom_range(0, 1));
        rst = 1'b0;
        a   = av;
        b   = bv;
        ci  = cv;
        exp_q.push_back({1'b0, 5'(av) + 5'(bv) + 5'(cv)});
      end
    end
  endtask

`ifdef RIPPLE_ADDER_4_OVF_EN
  task automatic test_overflow();
    drive(1'b0, 4'b0111, 4'b0001, 1'b0);
    total_cnt++;
    if (s !== 5'b01000 || ovf !== 1'b1) $display("FAIL ovf_pos: got s=%b ovf=%b expected s=01000 ovf=1", s, ovf);
    else pass_cnt++;
    drive(1'b0, 4'b1000, 4'b1111, 1'b0);
    total_cnt++;
    if (s !== 5'b10111 || ovf !== 1'b1) $display("FAIL ovf_neg: got s=%b ovf=%b expected s=10111 ovf=1", s, ovf);
    else pass_cnt++;
    drive(1'b0, 4'b0111, 4'b1101, 1'b1);
    total_cnt++;
    if (ovf !== 1'b0) $display("FAIL ovf_none: got ovf=%b expected 0", ovf);
    else pass_cnt++;
  endtask
`endif

  task automatic test_exhaustive();
    logic [5:0] ev;
    int         sres;
    int         errs;
    errs = 0;
    for (int i = 0; i <= 512; i++) begin
      @(negedge clk);
      if (i > 0) begin
        ev = exp_q.pop_front();
        total_cnt++;
`ifdef RIPPLE_ADDER_4_OVF_EN
        if (s !== ev[4:0] || ovf !== ev[5]) begin
          if (errs < 10) $display("FAIL exhaustive_%0d: got s=%b ovf=%b expected s=%b ovf=%b", i - 1, s, ovf, ev[4:0], ev[5]);
          errs++;
        end else pass_cnt++;
`else
        if (s !== ev[4:0]) begin
          if (errs < 10) $display("FAIL exhaustive_%0d: got %b expected %b", i - 1, s, ev[4:0]);
          errs++;
        end else pass_cnt++;
`endif
      end
      if (i < 512) begin
        rst = 1'b0;
        a   = 4'(i >> 5);
        b   = 4'(i >> 1);
        ci  = 1'(i);
        sres = int'($signed(a)) + int'($signed(b)) + int'(ci);
        exp_q.push_back({(sres > 7 || sres < -8), 5'(a) + 5'(b) + 5'(ci)});
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_back_to_back();
`ifdef RIPPLE_ADDER_4_OVF_EN
    test_overflow();
`endif
    test_exhaustive();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
